// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory request tracker and its controller-side
// packet interface.
//   - Line, address and ID widths plus the default outstanding-slot count.
//   - Packet type encoding used on both the issue and return paths.
//   - Per-slot tracking state.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int MEM_LINE_W = 512;
    localparam int MEM_ADDR_W = 36;
    localparam int MEM_NSLOT  = 16;
    localparam int MEM_ID_W   = 4;
    localparam int MEM_PKT_W  = 3;

    typedef enum logic [MEM_PKT_W-1:0] {
        PKT_IDLE    = 3'b000,
        PKT_WR      = 3'b001,
        PKT_RD      = 3'b011,
        PKT_WR_ACK  = 3'b101,
        PKT_RD_DATA = 3'b110
    } pkt_type_t;

    // A slot stays DONE (not FREE) until its response leaves the FIFO, which
    // is what bounds the FIFO occupancy to the slot count.
    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_PENDING,
        SLOT_DONE
    } slot_state_t;

endpackage

// File: rtl/resp_fifo.sv
// -----------------------------------------------------------------------------
// resp_fifo
// Synchronous first-word-fall-through FIFO with a registered occupancy count.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data write an entry (ignored when full)
//   pop             remove the head entry (ignored when empty)
//   pop_data        current head entry, valid while count != 0
//   full            count == DEPTH
//   count           number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign do_push  = push & ~full;
    assign do_pop   = pop & (count != '0);
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; the count and
    // pointers alone decide which entries are meaningful, and leaving the
    // array out of reset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/mem_req_tracker.sv
// -----------------------------------------------------------------------------
// mem_req_tracker
// Tracks up to NSLOT outstanding memory requests between a requester and a
// memory controller. Each accepted request takes the lowest FREE slot, whose
// number becomes the packet ID; the issue packet is registered and shown for
// one cycle. Matching controller responses are queued in arrival order and
// handed back to the requester; a slot is released only when its response
// is popped.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_write, req_addr, req_data  request payload
//   id_req_out, packet_type_req_out, addr_out, data_out   issued packet
//   id_req_in, packet_type_req_in, data_in                controller return
//   resp_valid/resp_ready      response handshake
//   resp_write, resp_addr, resp_data   response payload (data zero for writes)
//   outstanding                registered count of non-FREE slots
//   err                        sticky flag for any unexpected response
// -----------------------------------------------------------------------------
module mem_req_tracker
    import mem_pkg::*;
#(
    parameter int LINE_W = MEM_LINE_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int NSLOT  = MEM_NSLOT
) (
    input  logic                         clk,
    input  logic                         rst,
    // requester
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [LINE_W-1:0]            req_data,
    // to controller
    output logic [MEM_ID_W-1:0]          id_req_out,
    output logic [MEM_PKT_W-1:0]         packet_type_req_out,
    output logic [ADDR_W-1:0]            addr_out,
    output logic [LINE_W-1:0]            data_out,
    // from controller
    input  logic [MEM_ID_W-1:0]          id_req_in,
    input  logic [MEM_PKT_W-1:0]         packet_type_req_in,
    input  logic [LINE_W-1:0]            data_in,
    // responses
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic                         resp_write,
    output logic [ADDR_W-1:0]            resp_addr,
    output logic [LINE_W-1:0]            resp_data,
    output logic [$clog2(NSLOT+1)-1:0]   outstanding,
    output logic                         err
);

    localparam int ID_W    = MEM_ID_W;
    localparam int CNT_W   = $clog2(NSLOT + 1);
    localparam int ENTRY_W = 1 + ID_W + ADDR_W + LINE_W;

    slot_state_t        slot_state_q [NSLOT];
    slot_state_t        slot_state_d [NSLOT];
    logic               slot_write_q [NSLOT];
    logic [ADDR_W-1:0]  slot_addr_q  [NSLOT];

    logic               any_free;
    logic [ID_W-1:0]    alloc_id;
    logic               accept;
    logic               rsp_match;
    logic               rsp_bad;
    logic               push;
    logic               pop;
    logic [LINE_W-1:0]  rsp_data;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [ID_W-1:0]    head_id;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic [CNT_W-1:0]   outstanding_d;

    // Lowest-numbered FREE slot. A slot popped this cycle is still DONE here,
    // so it only becomes allocatable from the next cycle on.
    // NOTE: every signal driven from always_comb gets a default at the top so
    // no path leaves it unassigned and infers a latch.
    always_comb begin
        any_free = 1'b0;
        alloc_id = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (slot_state_q[i] == SLOT_FREE) begin
                any_free = 1'b1;
                alloc_id = ID_W'(i);
            end
        end
    end

    assign req_ready = ~rst & any_free;
    assign accept    = req_valid & req_ready;

    // A response is only legal for a PENDING slot and must carry the type
    // that matches the request direction stored at allocation.
    assign rsp_match = (slot_state_q[id_req_in] == SLOT_PENDING) &
                       (((packet_type_req_in == PKT_WR_ACK)  &  slot_write_q[id_req_in]) |
                        ((packet_type_req_in == PKT_RD_DATA) & ~slot_write_q[id_req_in]));
    assign rsp_bad   = (packet_type_req_in != PKT_IDLE) & ~rsp_match;
    // Slots free only on pop, so the FIFO can never be full on a legal push;
    // the gate just keeps the FIFO contract explicit.
    assign push      = rsp_match & ~fifo_full;

    assign rsp_data   = slot_write_q[id_req_in] ? '0 : data_in;
    assign push_entry = {slot_write_q[id_req_in], id_req_in, slot_addr_q[id_req_in], rsp_data};

    resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (NSLOT)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign resp_valid = (fifo_count != '0);
    assign pop        = resp_valid & resp_ready;
    assign resp_write = head_entry[ENTRY_W-1];
    assign head_id    = head_entry[LINE_W+ADDR_W +: ID_W];
    assign resp_addr  = head_entry[LINE_W +: ADDR_W];
    assign resp_data  = head_entry[LINE_W-1:0];

    // Issue, push and pop always touch three different slots (FREE, PENDING
    // and DONE respectively), so the three updates never collide.
    always_comb begin
        slot_state_d = slot_state_q;
        if (accept) begin
            slot_state_d[alloc_id] = SLOT_PENDING;
        end
        if (push) begin
            slot_state_d[id_req_in] = SLOT_DONE;
        end
        if (pop) begin
            slot_state_d[head_id] = SLOT_FREE;
        end
    end

    // Counting the next state lets the registered total line up with the
    // slot states it describes.
    always_comb begin
        outstanding_d = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (slot_state_d[i] != SLOT_FREE) begin
                outstanding_d = outstanding_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_state_q        <= '{default: SLOT_FREE};
            outstanding         <= '0;
            err                 <= 1'b0;
            id_req_out          <= '0;
            packet_type_req_out <= PKT_IDLE;
            addr_out            <= '0;
            data_out            <= '0;
        end else begin
            slot_state_q <= slot_state_d;
            outstanding  <= outstanding_d;
            if (rsp_bad) begin
                err <= 1'b1;
            end
            if (accept) begin
                id_req_out          <= alloc_id;
                packet_type_req_out <= req_write ? PKT_WR : PKT_RD;
                addr_out            <= req_addr;
                data_out            <= req_write ? req_data : '0;
            end else begin
                id_req_out          <= '0;
                packet_type_req_out <= PKT_IDLE;
                addr_out            <= '0;
                data_out            <= '0;
            end
        end
    end

    // Per-slot request attributes are only read while the slot is non-FREE.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_write_q[alloc_id] <= req_write;
            slot_addr_q[alloc_id]  <= req_addr;
        end
    end

endmodule
